// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic cells.
package serial_arith_pkg;

    localparam int SERIAL_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per cycle
// through a single full_sub cell with a registered borrow.
module serial_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] rs;
    logic             bq;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;

    full_sub u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (bq),
        .d    (d),
        .bout (bout)
    );

    // Control FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= {WIDTH{1'b0}};
            sb     <= {WIDTH{1'b0}};
            rs     <= {WIDTH{1'b0}};
            bq     <= 1'b0;
            cnt    <= {CW{1'b0}};
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= {WIDTH{1'b0}};
            borrow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        bq    <= 1'b0;
                        cnt   <= {CW{1'b0}};
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    rs  <= {d, rs[WIDTH-1:1]};
                    bq  <= bout;
                    cnt <= cnt + CW'(1);
                    // The last bit lands directly in diff, so the result is
                    // visible in the same cycle done pulses.
                    if (cnt == LAST) begin
                        diff   <= {d, rs[WIDTH-1:1]};
                        borrow <= bout;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: transaction-level model plus directed
// literal cases and randomized start/operand traffic.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int checks = 0;
    int errors = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    // Transaction model: an accepted request completes WIDTH edges later
    // with plain modular subtraction and an unsigned compare for borrow.
    logic         m_busy;
    logic         m_done;
    logic [W-1:0] m_diff;
    logic         m_borrow;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_a      <= '0;
            m_b      <= '0;
            m_left   <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    m_diff   <= m_a - m_b;
                    m_borrow <= (m_a < m_b);
                end
                m_left <= m_left - 1;
            end else if (start) begin
                m_busy <= 1'b1;
                m_left <= W;
                m_a    <= a;
                m_b    <= b;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic tick();
        @(negedge clk);
        chk("busy",   32'(busy),   32'(m_busy));
        chk("done",   32'(done),   32'(m_done));
        chk("diff",   32'(diff),   32'(m_diff));
        chk("borrow", 32'(borrow), 32'(m_borrow));
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                          input logic [W-1:0] ed, input logic eb, input string name);
        int j;
        tick();
        start = 1'b1; a = ta; b = tb2;
        tick();
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        chk({name, "_busy"}, 32'(busy), 32'd1);
        j = 0;
        while (!done && j < 20) begin
            tick();
            j++;
        end
        chk({name, "_latency"}, 32'(j), 32'(W));
        chk({name, "_diff"},    32'(diff), 32'(ed));
        chk({name, "_borrow"},  32'(borrow), 32'(eb));
    endtask

    initial begin
        int j;
        int ndone;
        tick();
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_diff",   32'(diff),   32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(8'd200, 8'd55,  8'h91, 1'b0, "basic");
        run_op(8'd5,   8'd10,  8'hFB, 1'b1, "underflow");
        run_op(8'hAA,  8'hAA,  8'h00, 1'b0, "equal");
        run_op(8'h00,  8'hFF,  8'h01, 1'b1, "zero_minus_max");
        run_op(8'hFF,  8'h00,  8'hFF, 1'b0, "max_minus_zero");

        // start and operand changes while busy are ignored
        tick();
        start = 1'b1; a = 8'd9; b = 8'd3;
        tick();
        start = 1'b0; a = 8'd77; b = 8'd12;
        tick();
        tick();
        start = 1'b1; a = 8'd1; b = 8'd2;
        tick();
        start = 1'b0; a = 8'd200; b = 8'd100;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) begin
                ndone++;
                chk("busy_ignore_diff",   32'(diff),   32'd6);
                chk("busy_ignore_borrow", 32'(borrow), 32'd0);
            end
        end
        chk("busy_ignore_count", 32'(ndone), 32'd1);

        // asynchronous reset in the 4th RUN cycle
        tick();
        start = 1'b1; a = 8'd50; b = 8'd60;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",   32'(busy),   32'd0);
        chk("arst_done",   32'(done),   32'd0);
        chk("arst_diff",   32'(diff),   32'd0);
        chk("arst_borrow", 32'(borrow), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);
        run_op(8'd7, 8'd7, 8'h00, 1'b0, "after_reset");

        // back-to-back: restart in the done cycle
        run_op(8'h30, 8'h10, 8'h20, 1'b0, "b2b_first");
        start = 1'b1; a = 8'd1; b = 8'd2;
        tick();
        start = 1'b0;
        j = 1;
        while (!done && j < 20) begin
            chk("b2b_hold", 32'(diff), 32'h20);
            tick();
            j++;
        end
        chk("b2b_spacing", 32'(j), 32'(W + 1));
        chk("b2b_diff",    32'(diff),   32'hFF);
        chk("b2b_borrow",  32'(borrow), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            tick();
            start = ($urandom_range(0, 3) == 0);
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
